rgb_hue_fade: RTL and testbench
===============================

// Module: rgb_hue_fade
// PURPOSE
// - Top-level LED driver. Sweeps the on-board RGB LED around the full hue circle once per second (12 MHz clk).
// - Six 60-degree hue phases. In each phase one channel ramps linearly; the other two are held full-on or full-off.
// - Brightness is produced by a per-channel PWM on a shared PWM_INTERVAL-clock period.
// - Outputs drive the active-low iCE40 RGB pads directly.
// PARAMETERS
// - PWM_INTERVAL     1250     clocks per PWM period; duty level range 0..PWM_INTERVAL
// - STEPS_PER_PHASE  250      brightness steps per hue phase
// - STEP_INTERVAL    8000     clocks between brightness steps (phase = 2,000,000 clk; cycle = 12,000,000 clk)
// - INC_DEC_VAL      PWM_INTERVAL/STEPS_PER_PHASE (5)   level change per step; must divide exactly
// PORTS
// - clk    in  1  system clock, 12 MHz nominal
// - rst_n  in  1  reset, asynchronous, active-low
// - RGB_R  out 1  red LED drive (0 = lit)
// - RGB_G  out 1  green LED drive (0 = lit)
// - RGB_B  out 1  blue LED drive (0 = lit)
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - phase=0, step_cnt=0, step_idx=0, pwm_cnt=0
//   - lvl_R=PWM_INTERVAL, lvl_G=0, lvl_B=0
//   - RGB_R=0, RGB_G=1, RGB_B=1
// - pwm_cnt: counts 0..PWM_INTERVAL-1, then wraps to 0.
// - Each output is a register, updated every clk to ~(pwm_cnt < lvl_x).
//   - Output lags the compare inputs by 1 clk.
//   - lvl=0: LED never lit. lvl=PWM_INTERVAL: LED always lit.
// - step_cnt: counts 0..STEP_INTERVAL-1. On wrap, a step fires:
//   - The ramping channel changes by INC_DEC_VAL.
//   - step_idx increments.
// - When step_idx reaches STEPS_PER_PHASE (on that same step):
//   - step_idx <= 0
//   - phase <= phase+1; phase 5 wraps to 0.
// - Phase table (ramp channel / held channels):
//   - 0: G up,   R=max, B=0
//   - 1: R down, G=max, B=0
//   - 2: B up,   G=max, R=0
//   - 3: G down, B=max, R=0
//   - 4: R up,   B=max, G=0
//   - 5: B down, R=max, G=0
// - Ramp end values: a ramping level lands exactly on 0 or PWM_INTERVAL at phase end. Levels never under/overflow.
//   - An implementation must saturate as a guard anyway.
// - Held channels are forced to their table value every clk.
// - Level widths: $clog2(PWM_INTERVAL+1) bits, unsigned.
// - Reset asserted mid-fade: all state returns to reset values immediately.
// CONFIGURATION
// - RGB_ACTIVE_HIGH_EN defined: outputs are non-inverted, RGB_x = (pwm_cnt < lvl_x).
//   - Reset outputs become R=1, G=0, B=0.
// - RGB_ACTIVE_HIGH_EN undefined (default): active-low as above.
// STRUCTURE
// - Package rgb_fade_pkg holds:
//   - phase_t enum (PH_RG, PH_GR, PH_GB, PH_BG, PH_BR, PH_RB)
//   - default timing localparams
//   - per-phase ramp/held lookup function
// - Sub-module fade_pwm_channel, instanced 3x:
//   - inputs: clk, rst_n, shared pwm_cnt, level
//   - output: registered pad bit (polarity per RGB_ACTIVE_HIGH_EN)
// - Top keeps pwm_cnt, step_cnt, step_idx, phase and the three level registers.
// TESTING
// - Reset, then release -> RGB_R=0 for all clk; RGB_G=1, RGB_B=1 for the first 2,000,000 clk minus ramp.
// - After 125 steps (1,000,000 clk), phase 0 -> lvl_G=625; RGB_G low for 625 of each 1250 clk.
// - At clk 2,000,000 -> phase=1, lvl_G=1250; RGB_G low continuously; lvl_R starts decreasing by 5.
// - At clk 12,000,000 -> phase wraps 5->0; levels R=1250, G=0, B=0 (matches reset).
// - Assert rst_n=0 at clk 3,000,123 -> outputs reach reset values without a clk edge; fade restarts at phase 0.
// - Override PWM_INTERVAL=100, STEPS_PER_PHASE=20, STEP_INTERVAL=10 -> INC_DEC_VAL=5; full cycle = 1200 clk; duty checks scale accordingly.

Source files
------------

// File: rtl/rgb_fade_pkg.sv
// rtl/rgb_fade_pkg.sv - hue phase enum, default timing and per-phase ramp/held lookup
// Shared by rgb_hue_fade and fade_pwm_channel. No ports.
package rgb_fade_pkg;

    // Default timing for a 12 MHz clock: one full hue sweep per second.
    localparam int DEF_PWM_INTERVAL    = 1250;
    localparam int DEF_STEPS_PER_PHASE = 250;
    localparam int DEF_STEP_INTERVAL   = 8000;

    // Phase names read as <from colour><to colour>.
    typedef enum logic [2:0] {
        PH_RG,
        PH_GR,
        PH_GB,
        PH_BG,
        PH_BR,
        PH_RB
    } phase_t;

    typedef enum logic [1:0] {
        CH_R,
        CH_G,
        CH_B
    } chan_t;

    // ramp names the channel that moves this phase; the *_full bits give the
    // held value of the other two (the ramp channel's own bit is ignored).
    typedef struct packed {
        chan_t ramp;
        logic  ramp_up;
        logic  r_full;
        logic  g_full;
        logic  b_full;
    } phase_cfg_t;

    function automatic phase_cfg_t phase_cfg(input phase_t p);
        phase_cfg_t c;
        case (p)
            PH_RG:   c = '{ramp: CH_G, ramp_up: 1'b1, r_full: 1'b1, g_full: 1'b0, b_full: 1'b0};
            PH_GR:   c = '{ramp: CH_R, ramp_up: 1'b0, r_full: 1'b0, g_full: 1'b1, b_full: 1'b0};
            PH_GB:   c = '{ramp: CH_B, ramp_up: 1'b1, r_full: 1'b0, g_full: 1'b1, b_full: 1'b0};
            PH_BG:   c = '{ramp: CH_G, ramp_up: 1'b0, r_full: 1'b0, g_full: 1'b0, b_full: 1'b1};
            PH_BR:   c = '{ramp: CH_R, ramp_up: 1'b1, r_full: 1'b0, g_full: 1'b0, b_full: 1'b1};
            PH_RB:   c = '{ramp: CH_B, ramp_up: 1'b0, r_full: 1'b1, g_full: 1'b0, b_full: 1'b0};
            default: c = '{ramp: CH_G, ramp_up: 1'b1, r_full: 1'b1, g_full: 1'b0, b_full: 1'b0};
        endcase
        return c;
    endfunction

    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        case (p)
            PH_RG:   n = PH_GR;
            PH_GR:   n = PH_GB;
            PH_GB:   n = PH_BG;
            PH_BG:   n = PH_BR;
            PH_BR:   n = PH_RB;
            default: n = PH_RG;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/fade_pwm_channel.sv
// rtl/fade_pwm_channel.sv - one registered PWM comparator driving an RGB pad
// Ports: clk, rst_n (async, active-low), pwm_cnt (shared period counter),
//        level (duty 0..PWM_INTERVAL), pad (registered LED drive).
// Polarity: active-low pad by default; RGB_ACTIVE_HIGH_EN defined gives active-high.
module fade_pwm_channel #(
    parameter int LW           = 11,
    parameter bit LIT_AT_RESET = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [LW-1:0] pwm_cnt,
    input  logic [LW-1:0] level,
    output logic          pad
);

`ifdef RGB_ACTIVE_HIGH_EN
    localparam logic PAD_RST = LIT_AT_RESET;
`else
    localparam logic PAD_RST = ~LIT_AT_RESET;
`endif

    logic lit;

    // level == 0 never lights; level == PWM_INTERVAL lights for every count.
    assign lit = (pwm_cnt < level);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad <= PAD_RST;
        end else begin
`ifdef RGB_ACTIVE_HIGH_EN
            pad <= lit;
`else
            pad <= ~lit;
`endif
        end
    end

endmodule

// File: rtl/rgb_hue_fade.sv
// rtl/rgb_hue_fade.sv - RGB LED hue-circle fader with per-channel PWM
// Ports: clk (12 MHz nominal), rst_n (async assert, active-low),
//        RGB_R / RGB_G / RGB_B (pad drives, 0 = lit unless RGB_ACTIVE_HIGH_EN).
// PWM_INTERVAL must be an exact multiple of STEPS_PER_PHASE so ramps land on 0 / full.
module rgb_hue_fade
    import rgb_fade_pkg::*;
#(
    parameter int PWM_INTERVAL    = DEF_PWM_INTERVAL,
    parameter int STEPS_PER_PHASE = DEF_STEPS_PER_PHASE,
    parameter int STEP_INTERVAL   = DEF_STEP_INTERVAL
) (
    input  logic clk,
    input  logic rst_n,
    output logic RGB_R,
    output logic RGB_G,
    output logic RGB_B
);

    localparam int INC_DEC_VAL = PWM_INTERVAL / STEPS_PER_PHASE;
    localparam int LW  = $clog2(PWM_INTERVAL + 1);
    localparam int SCW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
    localparam int SIW = (STEPS_PER_PHASE > 1) ? $clog2(STEPS_PER_PHASE) : 1;

    localparam logic [LW-1:0]  LVL_MAX  = LW'(PWM_INTERVAL);
    localparam logic [LW-1:0]  LVL_STEP = LW'(INC_DEC_VAL);
    localparam logic [LW-1:0]  PWM_LAST = LW'(PWM_INTERVAL - 1);
    localparam logic [SCW-1:0] STEP_CNT_LAST = SCW'(STEP_INTERVAL - 1);
    localparam logic [SIW-1:0] STEP_IDX_LAST = SIW'(STEPS_PER_PHASE - 1);

    // pwm_cnt shares the level width so the comparators need no extension.
    logic [LW-1:0]  pwm_cnt;
    logic [SCW-1:0] step_cnt;
    logic [SIW-1:0] step_idx;
    phase_t         phase;
    logic [LW-1:0]  lvl_r, lvl_g, lvl_b;
    logic [LW-1:0]  lvl_r_nxt, lvl_g_nxt, lvl_b_nxt;
    logic           step_fire;
    phase_cfg_t     cfg;

    assign step_fire = (step_cnt == STEP_CNT_LAST);

    // Ramp channel moves one saturating step when a step fires; held channels
    // are re-forced every clock so they can never drift from the table.
    function automatic logic [LW-1:0] next_lvl(
        input logic [LW-1:0] cur,
        input logic          is_ramp,
        input logic          up,
        input logic          full,
        input logic          fire
    );
        logic [LW-1:0] n;
        n = cur;
        if (!is_ramp) begin
            n = full ? LVL_MAX : '0;
        end else if (fire) begin
            if (up) begin
                n = (cur >= LVL_MAX - LVL_STEP) ? LVL_MAX : cur + LVL_STEP;
            end else begin
                n = (cur <= LVL_STEP) ? '0 : cur - LVL_STEP;
            end
        end
        return n;
    endfunction

    always_comb begin
        cfg       = phase_cfg(phase);
        lvl_r_nxt = next_lvl(lvl_r, cfg.ramp == CH_R, cfg.ramp_up, cfg.r_full, step_fire);
        lvl_g_nxt = next_lvl(lvl_g, cfg.ramp == CH_G, cfg.ramp_up, cfg.g_full, step_fire);
        lvl_b_nxt = next_lvl(lvl_b, cfg.ramp == CH_B, cfg.ramp_up, cfg.b_full, step_fire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt  <= '0;
            step_cnt <= '0;
            step_idx <= '0;
            phase    <= PH_RG;
            lvl_r    <= LVL_MAX;
            lvl_g    <= '0;
            lvl_b    <= '0;
        end else begin
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
            lvl_r   <= lvl_r_nxt;
            lvl_g   <= lvl_g_nxt;
            lvl_b   <= lvl_b_nxt;
            if (step_fire) begin
                step_cnt <= '0;
                // The final step of a phase both completes the ramp and advances.
                if (step_idx == STEP_IDX_LAST) begin
                    step_idx <= '0;
                    phase    <= next_phase(phase);
                end else begin
                    step_idx <= step_idx + 1'b1;
                end
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

    fade_pwm_channel #(.LW(LW), .LIT_AT_RESET(1'b1)) u_ch_r (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_cnt (pwm_cnt),
        .level   (lvl_r),
        .pad     (RGB_R)
    );

    fade_pwm_channel #(.LW(LW), .LIT_AT_RESET(1'b0)) u_ch_g (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_cnt (pwm_cnt),
        .level   (lvl_g),
        .pad     (RGB_G)
    );

    fade_pwm_channel #(.LW(LW), .LIT_AT_RESET(1'b0)) u_ch_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_cnt (pwm_cnt),
        .level   (lvl_b),
        .pad     (RGB_B)
    );

endmodule

// File: tb/tb_rgb_hue_fade.sv
// tb/tb_rgb_hue_fade.sv - self-checking bench for rgb_hue_fade at reduced timing
module tb_rgb_hue_fade;

    localparam int TP  = 100;  // PWM_INTERVAL
    localparam int TS  = 20;   // STEPS_PER_PHASE
    localparam int TI  = 10;   // STEP_INTERVAL
    localparam int INC = TP / TS;

`ifdef RGB_ACTIVE_HIGH_EN
    localparam bit ACTIVE_HIGH = 1'b1;
    localparam logic [2:0] RST_PADS = 3'b100;
`else
    localparam bit ACTIVE_HIGH = 1'b0;
    localparam logic [2:0] RST_PADS = 3'b011;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic RGB_R, RGB_G, RGB_B;

    int checks   = 0;
    int failures = 0;
    int n        = 0;  // clock edges since the last reset release

    rgb_hue_fade #(
        .PWM_INTERVAL    (TP),
        .STEPS_PER_PHASE (TS),
        .STEP_INTERVAL   (TI)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RGB_R (RGB_R),
        .RGB_G (RGB_G),
        .RGB_B (RGB_B)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    // Levels after e edges: every TI edges is one step, TS steps per phase,
    // six phases per colour-wheel turn; the ramp value is steps-into-phase * INC.
    function automatic void model_lvl(input int e, output int r, output int g, output int b);
        int steps, p, frac;
        steps = e / TI;
        p     = (steps / TS) % 6;
        frac  = (steps % TS) * INC;
        case (p)
            0:       begin r = TP;        g = frac;      b = 0;         end
            1:       begin r = TP - frac; g = TP;        b = 0;         end
            2:       begin r = 0;         g = TP;        b = frac;      end
            3:       begin r = 0;         g = TP - frac; b = TP;        end
            4:       begin r = frac;      g = 0;         b = TP;        end
            default: begin r = TP;        g = 0;         b = TP - frac; end
        endcase
    endfunction

    function automatic logic pad_of(input bit lit);
        return ACTIVE_HIGH ? lit : !lit;
    endfunction

    // Pads after e edges reflect the counter and levels as they stood one edge earlier.
    function automatic logic [2:0] model_pads(input int e);
        int r, g, b, pc;
        if (e == 0) return RST_PADS;
        model_lvl(e - 1, r, g, b);
        pc = (e - 1) % TP;
        return {pad_of(pc < r), pad_of(pc < g), pad_of(pc < b)};
    endfunction

    task automatic check3(input string name, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s n=%0d got RGB=%b expected RGB=%b", name, n, got, exp);
        end
    endtask

    task automatic check_lvl(input string name, input int e, input int er, input int eg, input int eb);
        int r, g, b;
        model_lvl(e, r, g, b);
        checks++;
        if (r != er || g != eg || b != eb) begin
            failures++;
            $display("FAIL %s e=%0d got lvl=%0d/%0d/%0d expected %0d/%0d/%0d", name, e, r, g, b, er, eg, eb);
        end
    endtask

    // Per-cycle compare against the model, sampled away from the active edge.
    always @(negedge clk) begin
        if ($time > 3) begin
            if (!rst_n) check3("cycle_rst", {RGB_R, RGB_G, RGB_B}, RST_PADS);
            else        check3("cycle", {RGB_R, RGB_G, RGB_B}, model_pads(n));
        end
    end

    initial begin
        // Hand-derived levels that pin the model to the phase table.
        check_lvl("model_reset",     0,    TP, 0,  0);
        check_lvl("model_half_ph0",  100,  100, 50, 0);
        check_lvl("model_ph1_start", 200,  100, 100, 0);
        check_lvl("model_ph1_step1", 210,  95, 100, 0);
        check_lvl("model_ph3_mid",   700,  0,  50, 100);
        check_lvl("model_ph5_last",  1199, 100, 0, 5);
        check_lvl("model_wrap",      1200, TP, 0,  0);

        #1 rst_n = 1'b0;
        #1 check3("async_rst_t0", {RGB_R, RGB_G, RGB_B}, RST_PADS);
        repeat (3) @(posedge clk);
        #1 check3("reset_hold", {RGB_R, RGB_G, RGB_B}, RST_PADS);
        #1 rst_n = 1'b1;

        // First edge: counter 0, R full, G/B zero.
        @(posedge clk);
        #1 check3("first_edge", {RGB_R, RGB_G, RGB_B}, RST_PADS);

        // Edge 1201 shows the wrapped state (levels back to reset, pwm_cnt 0).
        repeat (1200) @(posedge clk);
        #1 check3("wheel_wrap", {RGB_R, RGB_G, RGB_B}, RST_PADS);
        repeat (1300) @(posedge clk);

        // Random mid-fade resets, asserted between edges.
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(30, 1300)) @(posedge clk);
            #2 rst_n = 1'b0;
            #1 check3("async_rst_mid", {RGB_R, RGB_G, RGB_B}, RST_PADS);
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #2 rst_n = 1'b1;
        end
        repeat (1300) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
